// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared constants for the bit-serial subtractor controller: FSM encoding and
// the default operand width.
package serial_subtractor_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_subtractor_ctrl_sub_bit_cell.sv
// Combinational 1-bit full subtractor: two half-subtractor stages whose
// borrows are ORed together.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic hs1_d;
    logic hs1_b;
    logic hs2_b;

    assign hs1_d = a ^ b;
    assign hs1_b = ~a & b;

    // Second stage subtracts the incoming borrow from the first-stage difference.
    assign d     = hs1_d ^ bin;
    assign hs2_b = ~hs1_d & bin;

    assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: captures a and b on start, feeds one bit
// pair per clock through sub_bit_cell LSB-first and hands off diff/br with done.
module serial_subtractor_ctrl
    import serial_subtractor_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             br
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             borrow;
    logic             cell_d;
    logic             cell_bout;

    sub_bit_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // Result fills from the MSB side so the first (LSB) bit ends up at bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = cell_d;
        end else begin : g_res_wn
            assign res_next = {cell_d, res_sr[WIDTH-1:1]};
        end
    endgenerate

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking would chain the shifts within one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift registers are plain flops, not a memory, so they
            // are cleared with everything else to keep post-reset state known.
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            br     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    borrow <= cell_bout;
                    cnt    <= cnt + CNT_W'(1);
                    // Publish on the last bit so diff/br are valid alongside done.
                    if (cnt == LAST_CNT) begin
                        diff  <= res_next;
                        br    <= cell_bout;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl: an 8-bit and a 1-bit instance
// checked against plain-arithmetic expectations, including latency and busy length.
module tb_serial_subtractor_ctrl;

    typedef struct {
        logic [7:0] diff;
        logic       br;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start1;
    logic [7:0] a8, b8, diff8;
    logic [0:0] a1, b1, diff1;
    logic       busy8, done8, br8;
    logic       busy1, done1, br1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   run8 = 0;
    int   run1 = 0;
    exp_t q8[$];
    exp_t q1[$];

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .br(br8)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .br(br1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run8 = 0;
        end else begin
            if (busy8) run8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done8: done seen with no operation pending (cycle %0d)", cyc);
                end else begin
                    e = q8.pop_front();
                    check("diff8", diff8, e.diff);
                    check("br8", br8, e.br);
                    check("done8_cycle", cyc, e.cyc);
                    check("busy8_len", run8, 8);
                    check("busy_done8_excl", busy8, 0);
                end
                run8 = 0;
            end
        end
    end

    // Monitor for the 1-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            run1 = 0;
        end else begin
            if (busy1) run1++;
            if (done1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done1: done seen with no operation pending (cycle %0d)", cyc);
                end else begin
                    e = q1.pop_front();
                    check("diff1", diff1, e.diff);
                    check("br1", br1, e.br);
                    check("done1_cycle", cyc, e.cyc);
                    check("busy1_len", run1, 1);
                end
                run1 = 0;
            end
        end
    end

    // One 8-bit operation; operands are scrambled throughout RUN. A nonzero
    // inject index pulses start (a=b=1) during that RUN cycle.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input int inject);
        @(posedge clk); #1;
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        q8.push_back('{diff: 8'(av - bv), br: (av < bv), cyc: cyc + 1 + 8});
        @(posedge clk); #1;
        for (int i = 1; i <= 8; i++) begin
            a8     = 8'($urandom);
            b8     = 8'($urandom);
            start8 = (i == inject);
            if (i == inject) begin
                a8 = 8'h01;
                b8 = 8'h01;
            end
            @(posedge clk); #1;
        end
        start8 = 1'b0;
    endtask

    task automatic op1(input logic av, input logic bv);
        @(posedge clk); #1;
        start1 = 1'b1;
        a1     = av;
        b1     = bv;
        q1.push_back('{diff: {7'd0, av ^ bv}, br: (av < bv), cyc: cyc + 1 + 1});
        @(posedge clk); #1;
        start1 = 1'b0;
        a1     = 1'($urandom);
        b1     = 1'($urandom);
        @(posedge clk); #1;
    endtask

    initial begin
        rst    = 1'b1;
        start8 = 1'b0;
        start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_diff8", diff8, 0);
        check("rst_br8", br8, 0);
        check("rst_busy1", busy1, 0);
        check("rst_diff1", diff1, 0);
        rst = 1'b0;

        op8(8'd5, 8'd3, 0);
        op8(8'd3, 8'd5, 0);
        op8(8'h00, 8'h01, 0);
        op8(8'hA5, 8'hA5, 0);

        // A start pulsed mid-RUN must be neither accepted nor queued.
        op8(8'hF0, 8'h0F, 3);
        repeat (4) begin
            @(negedge clk);
            check("no_queued_start", busy8, 0);
        end

        // Abort an operation with reset during RUN cycle 4.
        @(posedge clk); #1;
        start8 = 1'b1;
        a8     = 8'h77;
        b8     = 8'h11;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy8", busy8, 0);
        check("abort_done8", done8, 0);
        check("abort_diff8", diff8, 0);
        check("abort_br8", br8, 0);
        rst = 1'b0;
        op8(8'd200, 8'd100, 0);

        for (int n = 0; n < 20; n++) begin
            op8(8'($urandom), 8'($urandom), 0);
        end

        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
